hdc_channel_scheduler: RTL and testbench

//  Collects one raw sample from each of NUM_CH independent channel streams and assembles them into one frame.

---
 rtl/hdc_channel_scheduler.sv | 166 ++++++++++++++++
 tb/tb_hdc_channel_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_channel_scheduler.sv
// ============================================================================
// Module  : hdc_channel_scheduler
// Brief   : Round-robin capture of one sample per channel into a frame, handed
//           downstream via valid/ready. Optional frame timeout is enabled by
//           defining HDC_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hdc_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int RAW_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic [NUM_CH-1:0]       ValidIn_SI,
    output logic [NUM_CH-1:0]       ReadyOut_SO,
    input  logic [NUM_CH*RAW_W-1:0] RawIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [NUM_CH*RAW_W-1:0] RawOut_DO,
    output logic [NUM_CH-1:0]       StaleMask_DO,
    output logic [15:0]             FrameCnt_DO
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("hdc_channel_scheduler: NUM_CH and TIMEOUT must both be at least 2");
    end

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t                    r_state;
    logic [NUM_CH-1:0]         r_got;
    logic [PTR_W-1:0]          r_ptr;
    logic [NUM_CH*RAW_W-1:0]   r_samples;
    logic [NUM_CH*RAW_W-1:0]   r_raw_out;
    logic                      r_valid_out;
    logic [15:0]               r_frame_cnt;

    logic [NUM_CH-1:0]         w_pending;
    logic [NUM_CH-1:0]         w_grant;
    logic [PTR_W-1:0]          w_grant_idx;
    logic                      w_grant_any;
    logic [PTR_W-1:0]          w_ptr_next;
    logic [NUM_CH-1:0]         w_got_next;
    logic [NUM_CH*RAW_W-1:0]   w_samples_next;
    logic                      w_complete;
    logic                      w_to_emit;

    assign w_pending = (r_state == S_COLLECT) ? (ValidIn_SI & ~r_got) : '0;

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin : p_grant
        int v_idx;
        v_idx       = 0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_CH) begin
                v_idx = v_idx - NUM_CH;
            end
            if (!w_grant_any && w_pending[v_idx]) begin
                w_grant_any    = 1'b1;
                w_grant[v_idx] = 1'b1;
                w_grant_idx    = PTR_W'(v_idx);
            end
        end
    end

    always_comb begin : p_capture
        w_samples_next = r_samples;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_samples_next[i*RAW_W +: RAW_W] = RawIn_DI[i*RAW_W +: RAW_W];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : (w_grant_idx + 1'b1);
    assign w_got_next = r_got | w_grant;
    assign w_complete = w_grant_any && (w_got_next == {NUM_CH{1'b1}});

`ifdef HDC_SCHED_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;

    logic [TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0] r_stale;
    logic              w_timeout;

    // Got is never all-ones while collecting, so a nonzero Got is the only guard needed.
    assign w_timeout    = (r_state == S_COLLECT) && (r_got != '0) &&
                          (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_to_emit    = w_complete || w_timeout;
    assign StaleMask_DO = r_stale;
`else
    assign w_to_emit    = w_complete;
    assign StaleMask_DO = '0;
`endif

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_state     <= S_COLLECT;
            r_got       <= '0;
            r_ptr       <= '0;
            r_samples   <= '0;
            r_raw_out   <= '0;
            r_valid_out <= 1'b0;
            r_frame_cnt <= '0;
`ifdef HDC_SCHED_TIMEOUT_EN
            r_timer     <= '0;
            r_stale     <= '0;
`endif
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_grant_any) begin
                        r_samples <= w_samples_next;
                        r_got     <= w_got_next;
                        r_ptr     <= w_ptr_next;
                    end
`ifdef HDC_SCHED_TIMEOUT_EN
                    if (r_got != '0) begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                    if (w_to_emit) begin
                        r_state     <= S_EMIT;
                        r_valid_out <= 1'b1;
                        r_raw_out   <= w_samples_next;
`ifdef HDC_SCHED_TIMEOUT_EN
                        r_stale     <= ~w_got_next;
`endif
                    end
                end
                S_EMIT: begin
                    if (ReadyIn_SI) begin
                        r_state     <= S_COLLECT;
                        r_valid_out <= 1'b0;
                        r_got       <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef HDC_SCHED_TIMEOUT_EN
                        r_timer     <= '0;
`endif
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign ReadyOut_SO = w_grant;
    assign ValidOut_SO = r_valid_out;
    assign RawOut_DO   = r_raw_out;
    assign FrameCnt_DO = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hdc_channel_scheduler.sv
// ============================================================================
// Module  : tb_hdc_channel_scheduler
// Brief   : Directed, table-driven bench for hdc_channel_scheduler (4 x 8 bit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdc_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid_in = '0;
    logic [3:0]  ready_out;
    logic [31:0] raw_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [31:0] raw_out;
    logic [3:0]  stale;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hdc_channel_scheduler #(
        .NUM_CH (4),
        .RAW_W  (8),
        .TIMEOUT(16)
    ) dut (
        .Clk_CI      (clk),
        .Reset_RI    (rst),
        .ValidIn_SI  (valid_in),
        .ReadyOut_SO (ready_out),
        .RawIn_DI    (raw_in),
        .ValidOut_SO (valid_out),
        .ReadyIn_SI  (ready_in),
        .RawOut_DO   (raw_out),
        .StaleMask_DO(stale),
        .FrameCnt_DO (frame_cnt)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] raw;
        logic        ready;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_raw;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] v, input logic [31:0] r, input logic rd,
                       input logic [3:0] erdy, input logic evld, input logic [31:0] eraw,
                       input logic [15:0] ecnt);
        vec_t e;
        e.valid = v; e.raw = r; e.ready = rd;
        e.exp_rdy = erdy; e.exp_vld = evld; e.exp_raw = eraw; e.exp_cnt = ecnt;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    localparam logic [31:0] RAW1 = 32'h44332211;
    localparam logic [31:0] RAW2 = 32'hA4A3A2A1;
    localparam logic [31:0] RAW3 = 32'h13121110;
    localparam logic [31:0] RAW4 = 32'h23222120;
    localparam logic [31:0] RAW5 = 32'h55565758;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        logic [15:0] cnt_before;

        // Frame 1: all valid, always-ready sink.
        for (int i = 0; i < 4; i++) add(4'hF, RAW1, 1'b1, 4'(1 << i), 1'b0, '0, 16'd0);
        add(4'hF, RAW1, 1'b1, 4'b0000, 1'b1, RAW1, 16'd0);
        // Frame 2: sink stalls 10 cycles in EMIT.
        for (int i = 0; i < 4; i++) add(4'hF, RAW2, 1'b0, 4'(1 << i), 1'b0, '0, 16'd1);
        for (int i = 0; i < 10; i++) add(4'hF, RAW2, 1'b0, 4'b0000, 1'b1, RAW2, 16'd1);
        add(4'hF, RAW2, 1'b1, 4'b0000, 1'b1, RAW2, 16'd1);
        // Frame 3: last capture is ch1.
        add(4'b1101, RAW3, 1'b1, 4'b0001, 1'b0, '0, 16'd2);
        add(4'b1101, RAW3, 1'b1, 4'b0100, 1'b0, '0, 16'd2);
        add(4'b1101, RAW3, 1'b1, 4'b1000, 1'b0, '0, 16'd2);
        add(4'b1111, RAW3, 1'b1, 4'b0010, 1'b0, '0, 16'd2);
        add(4'b1111, RAW3, 1'b1, 4'b0000, 1'b1, RAW3, 16'd2);
        // Frame 4: rotation resumes at ch2.
        add(4'hF, RAW4, 1'b1, 4'b0100, 1'b0, '0, 16'd3);
        add(4'hF, RAW4, 1'b1, 4'b1000, 1'b0, '0, 16'd3);
        add(4'hF, RAW4, 1'b1, 4'b0001, 1'b0, '0, 16'd3);
        add(4'hF, RAW4, 1'b1, 4'b0010, 1'b0, '0, 16'd3);
        add(4'hF, RAW4, 1'b1, 4'b0000, 1'b1, RAW4, 16'd3);

        repeat (2) @(posedge clk);
        next_cycle();
        rst = 1'b0;
        #1;
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_cnt", 32'(frame_cnt), 32'd0);
        check("reset_ready", 32'(ready_out), 32'd0);
        check("reset_raw", raw_out, 32'd0);
        check("reset_stale", 32'(stale), 32'd0);

        foreach (tbl[i]) begin
            next_cycle();
            valid_in = tbl[i].valid;
            raw_in   = tbl[i].raw;
            ready_in = tbl[i].ready;
            #1;
            check($sformatf("v%0d_ready", i), 32'(ready_out), 32'(tbl[i].exp_rdy));
            check($sformatf("v%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_vld));
            check($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("v%0d_stale", i), 32'(stale), 32'd0);
            if (tbl[i].exp_vld) check($sformatf("v%0d_raw", i), raw_out, tbl[i].exp_raw);
        end

`ifdef HDC_SCHED_TIMEOUT_EN
        // Only ch0/ch1 valid: frame closes on the timeout.
        next_cycle();
        valid_in = 4'b0011;
        raw_in   = 32'h99983130;
        ready_in = 1'b1;
        #1;
        check("to_grant_ch0", 32'(ready_out), 32'b0001);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            #1;
            if (k == 1) check("to_grant_ch1", 32'(ready_out), 32'b0010);
            if (valid_out) begin
                cyc = k;
                break;
            end
        end
        check("to_latency", cyc, 17);
        check("to_stale", 32'(stale), 32'b1100);
        check("to_raw", raw_out, 32'h23223130);
        next_cycle();
        #1;
        check("to_accept_cnt", 32'(frame_cnt), 32'd5);
        check("to_accept_valid", 32'(valid_out), 32'd0);
        cnt_before = 16'd5;
`else
        // ch3 never valid: nothing completes and ch0-2 are not re-granted.
        next_cycle();
        valid_in = 4'b0111;
        raw_in   = RAW5;
        ready_in = 1'b1;
        #1;
        check("nt_grant_ch2", 32'(ready_out), 32'b0100);
        next_cycle();
        #1;
        check("nt_grant_ch0", 32'(ready_out), 32'b0001);
        next_cycle();
        #1;
        check("nt_grant_ch1", 32'(ready_out), 32'b0010);
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            next_cycle();
            #1;
            if (ready_out != 4'b0 || valid_out || stale != 4'b0) bad++;
        end
        check("nt_idle_violations", bad, 0);
        cnt_before = 16'd4;
`endif

        // Reach EMIT with a stalled sink, then reset mid-EMIT.
        next_cycle();
        valid_in = 4'hF;
        raw_in   = RAW5;
        ready_in = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (valid_out) begin
                cyc = k;
                break;
            end
            next_cycle();
        end
        check("rs_reached_emit", 32'(cyc != 0), 32'd1);
        check("rs_emit_raw", raw_out, RAW5);
        check("rs_emit_cnt", 32'(frame_cnt), 32'(cnt_before));
        check("rs_emit_ready", 32'(ready_out), 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rs_valid", 32'(valid_out), 32'd0);
        check("rs_cnt", 32'(frame_cnt), 32'd0);
        check("rs_grant0", 32'(ready_out), 32'b0001);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            #1;
            check($sformatf("rs_grant%0d", i), 32'(ready_out), 32'(1 << i));
        end
        next_cycle();
        ready_in = 1'b1;
        #1;
        check("rs_frame_valid", 32'(valid_out), 32'd1);
        next_cycle();
        #1;
        check("rs_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
